// File: rtl/interface_hcsr04_uc.sv
// Control unit for the HC-SR04 datapath: clear, trigger, wait for the echo
// (with timeout), latch the distance, and optionally repeat after an interval.
module interface_hcsr04_uc #(
    parameter int TIMEOUT_CLKS   = 2000000,
    parameter int INTERVALO_CLKS = 3000000,
    parameter int W              = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       modo_continuo,
    input  logic       fim_medida,
    output logic       zera,
    output logic       gera,
    output logic       registra,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        ENVIA_TRIGGER = 4'h2,
        ESPERA_ECO    = 4'h3,
        ARMAZENA      = 4'h4,
        FINAL         = 4'h5,
        INTERVALO     = 4'h6,
        ERRO          = 4'hF
    } estado_t;

    localparam logic [W-1:0] TIMEOUT_FIM   = W'(TIMEOUT_CLKS - 1);
    localparam logic [W-1:0] INTERVALO_FIM = W'(INTERVALO_CLKS - 1);

    estado_t        estado_q, estado_d;
    logic [W-1:0]   conta_q, conta_d;
    logic           erro_q, erro_d;

    // State register, cycle counter and sticky error flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= INICIAL;
            conta_q  <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            conta_q  <= conta_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state logic; fim_medida wins over timeout in ESPERA_ECO
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (medir || modo_continuo) estado_d = PREPARA;
                else                        estado_d = INICIAL;
            end
            PREPARA:       estado_d = ENVIA_TRIGGER;
            ENVIA_TRIGGER: estado_d = ESPERA_ECO;
            ESPERA_ECO: begin
                if (fim_medida)                  estado_d = ARMAZENA;
                else if (conta_q == TIMEOUT_FIM) estado_d = ERRO;
                else                             estado_d = ESPERA_ECO;
            end
            ARMAZENA:      estado_d = FINAL;
            FINAL: begin
                if (modo_continuo) estado_d = INTERVALO;
                else               estado_d = INICIAL;
            end
            INTERVALO: begin
                if (!modo_continuo)                estado_d = INICIAL;
                else if (conta_q == INTERVALO_FIM) estado_d = PREPARA;
                else                               estado_d = INTERVALO;
            end
            ERRO: begin
                if (modo_continuo) estado_d = INTERVALO;
                else if (medir)    estado_d = PREPARA;
                else               estado_d = ERRO;
            end
            default:       estado_d = INICIAL;
        endcase
    end

    // Counter runs only while staying in a counting state, so every exit clears it
    always_comb begin
        if ((estado_q == ESPERA_ECO || estado_q == INTERVALO) && (estado_d == estado_q)) begin
            conta_d = conta_q + W'(1);
        end else begin
            conta_d = '0;
        end
        if (estado_d == ERRO) begin
            erro_d = 1'b1;
        end else if (estado_d == PREPARA) begin
            erro_d = 1'b0;
        end else begin
            erro_d = erro_q;
        end
    end

    // Moore output decode
    always_comb begin
        zera      = 1'b0;
        gera      = 1'b0;
        registra  = 1'b0;
        pronto    = 1'b0;
        erro      = erro_q;
        db_estado = estado_q;
        case (estado_q)
            PREPARA:       zera     = 1'b1;
            ENVIA_TRIGGER: gera     = 1'b1;
            ARMAZENA:      registra = 1'b1;
            FINAL:         pronto   = 1'b1;
            default: begin
                zera     = 1'b0;
                gera     = 1'b0;
                registra = 1'b0;
                pronto   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// Self-checking bench for interface_hcsr04_uc: directed scenarios plus randomized
// single measurements, with expected traces built from the measurement rules.
module tb_interface_hcsr04_uc;

    localparam int TO     = 50;
    localparam int IV     = 20;
    localparam int ECHO_K = 10;
    localparam int PERIOD = 1 + IV + 1 + 1 + (ECHO_K + 1) + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       medir;
    logic       modo_continuo;
    logic       fim_medida;
    logic       zera;
    logic       gera;
    logic       registra;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_pronto = -1;
    int         prev_pronto = -1;
    logic [3:0] cur_st = 4'h0;
    bit         cur_err = 1'b0;

    interface_hcsr04_uc #(
        .TIMEOUT_CLKS  (TO),
        .INTERVALO_CLKS(IV),
        .W             (22)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .medir        (medir),
        .modo_continuo(modo_continuo),
        .fim_medida   (fim_medida),
        .zera         (zera),
        .gera         (gera),
        .registra     (registra),
        .pronto       (pronto),
        .erro         (erro),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    function automatic bit rbit(input bit en);
        return en && ($urandom_range(0, 1) == 1);
    endfunction

    // One clock: drive inputs, then check the state/outputs seen after the edge
    task automatic step(input bit m, input bit md, input bit f, input bit r,
                        input logic [3:0] es, input bit ee, input string tag);
        logic [8:0] obs;
        logic [8:0] exp_v;
        medir         = m;
        modo_continuo = md;
        fim_medida    = f;
        reset         = r;
        @(posedge clock);
        #1;
        cyc++;
        obs   = {db_estado, zera, gera, registra, pronto, erro};
        exp_v = {es, es == 4'h1, es == 4'h2, es == 4'h4, es == 4'h5, ee};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
        if (pronto === 1'b1) begin
            prev_pronto = last_pronto;
            last_pronto = cyc;
        end
    endtask

    task automatic idle(input int n, input bit noisy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rbit(noisy), 1'b1, cur_st, cur_err, "idle");
    endtask

    // Single measurement started by medir; echo arrives d cycles into ESPERA_ECO
    task automatic measure(input int d, input bit n);
        step(1'b1, 1'b0, rbit(n), 1'b1, 4'h1, 1'b0, "prepara");
        cur_err = 1'b0;
        step(rbit(n), 1'b0, rbit(n), 1'b1, 4'h2, 1'b0, "trigger");
        step(rbit(n), 1'b0, rbit(n), 1'b1, 4'h3, 1'b0, "espera_in");
        for (int k = 0; k < TO; k++) begin
            if (k == d) begin
                step(rbit(n), 1'b0, 1'b1, 1'b1, 4'h4, 1'b0, "registra");
                step(rbit(n), 1'b0, rbit(n), 1'b1, 4'h5, 1'b0, "pronto");
                step(rbit(n), 1'b0, rbit(n), 1'b1, 4'h0, 1'b0, "back_idle");
                cur_st = 4'h0;
                return;
            end else if (k == TO - 1) begin
                step(rbit(n), 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, "timeout");
                cur_st  = 4'hF;
                cur_err = 1'b1;
                return;
            end else begin
                step(rbit(n), 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, "espera");
            end
        end
    endtask

    task automatic interval_run();
        for (int j = 0; j < IV - 1; j++)
            step(rbit(1'b1), 1'b1, rbit(1'b1), 1'b1, 4'h6, cur_err, "intervalo");
        step(rbit(1'b1), 1'b1, rbit(1'b1), 1'b1, 4'h1, 1'b0, "int_to_prep");
        cur_err = 1'b0;
    endtask

    task automatic cycle_run();
        step(rbit(1'b1), 1'b1, rbit(1'b1), 1'b1, 4'h2, 1'b0, "c_trigger");
        step(rbit(1'b1), 1'b1, rbit(1'b1), 1'b1, 4'h3, 1'b0, "c_espera_in");
        for (int k = 0; k < ECHO_K; k++)
            step(rbit(1'b1), 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, "c_espera");
        step(rbit(1'b1), 1'b1, 1'b1, 1'b1, 4'h4, 1'b0, "c_registra");
        step(rbit(1'b1), 1'b1, rbit(1'b1), 1'b1, 4'h5, 1'b0, "c_pronto");
        step(rbit(1'b1), 1'b1, rbit(1'b1), 1'b1, 4'h6, 1'b0, "c_to_int");
    endtask

    // Continuous mode for a number of periods, then modo_continuo dropped
    task automatic cont(input bit from_err, input int periods);
        if (from_err) begin
            step(1'b1, 1'b1, rbit(1'b1), 1'b1, 4'h6, 1'b1, "err_to_int");
            interval_run();
        end else begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, "cont_start");
            cur_err = 1'b0;
        end
        for (int p = 0; p < periods; p++) begin
            cycle_run();
            if (p > 0) begin
                checks++;
                assert ((last_pronto - prev_pronto) === PERIOD) else begin
                    failures++;
                    $error("FAIL pronto_period observed=%0d expected=%0d",
                           last_pronto - prev_pronto, PERIOD);
                end
            end
            if (p < periods - 1) interval_run();
        end
        for (int j = 0; j < 3; j++) step(rbit(1'b1), 1'b1, rbit(1'b1), 1'b1, 4'h6, 1'b0, "int_hold");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "drop_modo");
        cur_st = 4'h0;
    endtask

    initial begin
        medir = 1'b0; modo_continuo = 1'b0; fim_medida = 1'b0; reset = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "reset0");
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, "reset1");
        idle(2, 1'b1);

        measure(27, 1'b0);           // fim_medida at cycle 30 after medir
        idle(2, 1'b0);
        measure(99, 1'b0);           // no echo: timeout into ERRO
        idle(3, 1'b1);               // erro held, state F
        measure(5, 1'b0);            // medir from ERRO clears erro
        measure(TO - 1, 1'b0);       // echo on the timeout cycle
        idle(1, 1'b0);
        measure(12, 1'b1);           // medir/fim noise outside their windows

        cont(1'b0, 3);
        measure(99, 1'b0);
        cont(1'b1, 2);               // ERRO -> INTERVALO with modo_continuo

        // Reset mid-measurement, then a stray fim_medida
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, "r_prepara");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, "r_trigger");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, "r_espera_in");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, "r_espera");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "rst_mid");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, "fim_ignored");
        cur_st = 4'h0; cur_err = 1'b0;

        for (int t = 0; t < 12; t++) begin
            measure($urandom_range(0, 55), 1'b1);
            idle($urandom_range(0, 3), 1'b1);
        end

        if (cur_st != 4'hF) measure(99, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, "rst_from_erro");
        cur_st = 4'h0; cur_err = 1'b0;
        idle(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
